// File: rtl/cache_way_engine.sv
// cache_way_engine: set-associative tag/MESI/LRU-age engine that asks an external
// MESI FSM for the next state and commits one array update per request.
module cache_way_engine #(
    parameter int WAYS  = 8,
    parameter int SETS  = 16,
    parameter int TAG_W = 12,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mesi_req_valid,
    output logic [1:0]       mesi_cur,
    output logic             mesi_hit,
    input  logic             mesi_rsp_valid,
    input  logic [1:0]       mesi_next,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WAY_W-1:0] resp_way,
    output logic             resp_evict,
    output logic             resp_victim_dirty,
    output logic [TAG_W-1:0] resp_victim_tag,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      evict_count
);
    typedef enum logic [2:0] {IDLE, LOOKUP, COHERE, UPDATE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tags_q [SETS][WAYS];
    logic [1:0]       mesi_q [SETS][WAYS];
    logic [WAY_W-1:0] age_q  [SETS][WAYS];
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx_q, clr_q;
    logic [TAG_W-1:0] rtag_q;
    logic             hit_q;
    logic [WAY_W-1:0] way_q;
    logic [1:0]       nxt_q;
    logic [31:0]      hit_cnt_q, miss_cnt_q, evict_cnt_q;
    logic             hit_c, inv_c;
    logic [WAY_W-1:0] hit_way_c, inv_way_c, inv_age_c, old_way_c, sel_c;
    logic             rw, snoop, upd;
    logic [1:0]       sel_mesi;
    logic [TAG_W-1:0] sel_tag;

    assign rw       = op_q <= 3'd1;
    assign snoop    = op_q == 3'd2 || op_q == 3'd3;
    assign upd      = state_q == UPDATE;
    assign sel_mesi = mesi_q[idx_q][way_q];
    assign sel_tag  = tags_q[idx_q][way_q];

    // Ages form a permutation, so exactly one way carries age WAYS-1.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_c     = 1'b0;
        inv_way_c = '0;
        inv_age_c = '0;
        old_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mesi_q[idx_q][w] != 2'd0 && tags_q[idx_q][w] == rtag_q) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (mesi_q[idx_q][w] == 2'd0 && (!inv_c || age_q[idx_q][w] > inv_age_c)) begin
                inv_c     = 1'b1;
                inv_way_c = WAY_W'(w);
                inv_age_c = age_q[idx_q][w];
            end
            if (age_q[idx_q][w] == WAY_W'(WAYS - 1))
                old_way_c = WAY_W'(w);
        end
    end

    assign sel_c = hit_c ? hit_way_c : inv_c ? inv_way_c : old_way_c;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !req_valid ? IDLE : req_op == 3'd4 ? CLEAR : LOOKUP;
            LOOKUP:  state_d = (rw || (snoop && hit_c)) ? COHERE : UPDATE;
            COHERE:  state_d = mesi_rsp_valid ? UPDATE : COHERE;
            CLEAR:   state_d = clr_q == IDX_W'(SETS - 1) ? UPDATE : CLEAR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign req_ready         = state_q == IDLE;
    assign mesi_req_valid    = state_q == COHERE;
    assign mesi_cur          = mesi_req_valid ? sel_mesi : 2'd0;
    assign mesi_hit          = mesi_req_valid && hit_q;
    assign resp_valid        = upd;
    assign resp_hit          = upd && (rw || snoop) && hit_q;
    assign resp_way          = (upd && (rw || resp_hit)) ? way_q : '0;
    assign resp_evict        = upd && rw && !hit_q && sel_mesi != 2'd0;
    assign resp_victim_dirty = resp_evict && sel_mesi == 2'd3;
    assign resp_victim_tag   = resp_evict ? sel_tag : '0;
    assign hit_count         = hit_cnt_q;
    assign miss_count        = miss_cnt_q;
    assign evict_count       = evict_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    tags_q[s][w] <= '0;
                    mesi_q[s][w] <= 2'd0;
                    age_q[s][w]  <= WAY_W'(w);
                end
            op_q        <= '0;
            idx_q       <= '0;
            clr_q       <= '0;
            rtag_q      <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            nxt_q       <= 2'd0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else begin
            if (req_valid && req_ready) begin
                op_q   <= req_op;
                idx_q  <= req_idx;
                rtag_q <= req_tag;
                clr_q  <= '0;
            end
            if (state_q == LOOKUP) begin
                hit_q <= hit_c;
                way_q <= sel_c;
            end
            if (mesi_req_valid && mesi_rsp_valid)
                nxt_q <= mesi_next;
            if (state_q == CLEAR) begin
                for (int w = 0; w < WAYS; w++) begin
                    tags_q[clr_q][w] <= '0;
                    mesi_q[clr_q][w] <= 2'd0;
                    age_q[clr_q][w]  <= WAY_W'(w);
                end
                clr_q <= clr_q + IDX_W'(1);
            end
            if (upd && rw) begin
                tags_q[idx_q][way_q] <= rtag_q;
                mesi_q[idx_q][way_q] <= nxt_q;
                for (int w = 0; w < WAYS; w++)
                    if (WAY_W'(w) == way_q)
                        age_q[idx_q][w] <= '0;
                    else if (age_q[idx_q][w] < age_q[idx_q][way_q])
                        age_q[idx_q][w] <= age_q[idx_q][w] + WAY_W'(1);
                if (hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
                else       miss_cnt_q <= sat_inc(miss_cnt_q);
                if (resp_evict) evict_cnt_q <= sat_inc(evict_cnt_q);
            end
            if (upd && snoop && hit_q)
                mesi_q[idx_q][way_q] <= nxt_q;
        end
    end
endmodule

// File: tb/tb_cache_way_engine.sv
// tb_cache_way_engine: directed and randomized traffic checked cycle by cycle
// against a recency-list model of the cache kept in the bench.
module tb_cache_way_engine;
    localparam int WAYS  = 8;
    localparam int SETS  = 16;
    localparam int TAG_W = 12;
    localparam int IDX_W = 4;
    localparam int WAY_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [2:0]       req_op = '0;
    logic [IDX_W-1:0] req_idx = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             mesi_rsp_valid = 1'b0;
    logic [1:0]       mesi_next = '0;
    logic             req_ready, mesi_req_valid, mesi_hit, resp_valid, resp_hit;
    logic             resp_evict, resp_victim_dirty;
    logic [1:0]       mesi_cur;
    logic [WAY_W-1:0] resp_way;
    logic [TAG_W-1:0] resp_victim_tag;
    logic [31:0]      hit_count, miss_count, evict_count;

    cache_way_engine #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_idx(req_idx), .req_tag(req_tag),
        .mesi_req_valid(mesi_req_valid), .mesi_cur(mesi_cur), .mesi_hit(mesi_hit),
        .mesi_rsp_valid(mesi_rsp_valid), .mesi_next(mesi_next),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_evict(resp_evict), .resp_victim_dirty(resp_victim_dirty),
        .resp_victim_tag(resp_victim_tag),
        .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: per-set tags, MESI, and recency order (index 0 = most recently used).
    int m_tag  [SETS][WAYS];
    int m_mesi [SETS][WAYS];
    int m_ord  [SETS][WAYS];
    longint c_old [3];
    longint c_new [3];

    int  n_chk = 0, n_fail = 0;
    bit  chk_en = 0;
    int  acc_cyc = -100, resp_cyc = -1, busy_lo = 1, busy_hi = 0, coh_lo = 1, coh_hi = 0;
    int  e_mcur, e_mhit, e_hit, e_way, e_ev, e_vtag, e_vd;
    int  lr_mcur, lr_mhit, lr_hit, lr_way, lr_ev, lr_vtag, lr_vd, lr_lat;
    bit  in_coh, is_rsp, past_rsp;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w]  = 0;
                m_mesi[s][w] = 0;
                m_ord[s][w]  = w;
            end
    endfunction

    function automatic int victim(input int s);
        for (int k = WAYS - 1; k >= 0; k--)
            if (m_mesi[s][m_ord[s][k]] == 0) return m_ord[s][k];
        return m_ord[s][WAYS-1];
    endfunction

    function automatic void touch(input int s, input int w);
        int k = 0;
        while (m_ord[s][k] != w) k++;
        for (int j = k; j > 0; j--) m_ord[s][j] = m_ord[s][j-1];
        m_ord[s][0] = w;
    endfunction

    function automatic longint sat(input longint v);
        return v >= 64'hFFFF_FFFF ? v : v + 1;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_up();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    // Compare process: every cycle, all outputs against the current expectation window.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (chk_en) begin
                in_coh   = cyc >= coh_lo && cyc <= coh_hi;
                is_rsp   = cyc == resp_cyc;
                past_rsp = cyc > resp_cyc;
                chk("req_ready", req_ready, !(cyc >= busy_lo && cyc <= busy_hi));
                chk("mesi_req_valid", mesi_req_valid, in_coh);
                chk("mesi_cur", mesi_cur, in_coh ? e_mcur : 0);
                chk("mesi_hit", mesi_hit, in_coh ? e_mhit : 0);
                chk("resp_valid", resp_valid, is_rsp);
                chk("resp_hit", resp_hit, is_rsp ? e_hit : 0);
                chk("resp_way", resp_way, is_rsp ? e_way : 0);
                chk("resp_evict", resp_evict, is_rsp ? e_ev : 0);
                chk("resp_victim_tag", resp_victim_tag, is_rsp ? e_vtag : 0);
                chk("resp_victim_dirty", resp_victim_dirty, is_rsp ? e_vd : 0);
                chk("hit_count", hit_count, past_rsp ? c_new[0] : c_old[0]);
                chk("miss_count", miss_count, past_rsp ? c_new[1] : c_old[1]);
                chk("evict_count", evict_count, past_rsp ? c_new[2] : c_old[2]);
                if (mesi_req_valid) begin
                    lr_mcur = int'(mesi_cur);
                    lr_mhit = int'(mesi_hit);
                end
                if (resp_valid) begin
                    lr_hit  = int'(resp_hit);
                    lr_way  = int'(resp_way);
                    lr_ev   = int'(resp_evict);
                    lr_vtag = int'(resp_victim_tag);
                    lr_vd   = int'(resp_victim_dirty);
                    lr_lat  = cyc - acc_cyc;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, expected completion");
        n_fail++;
        finish_up();
    end

    // Called at a negedge; returns at the negedge of the first idle cycle after the response.
    task automatic txn(input int op, input int idx, input int tag, input int stall, input int nxt);
        int hw, sel, lat, a, guard;
        bit rw, sn, coh;
        guard = 0;
        while (!req_ready) begin
            @(negedge clk);
            if (++guard > 200) begin
                chk("ready_timeout", 0, 1);
                finish_up();
            end
        end
        a  = cyc;
        rw = op < 2;
        sn = op == 2 || op == 3;
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_mesi[idx][w] != 0 && m_tag[idx][w] == tag) hw = w;
        sel = hw >= 0 ? hw : victim(idx);
        coh = rw || (sn && hw >= 0);
        lat = op == 4 ? SETS + 1 : coh ? 3 + stall : 2;
        e_hit  = ((rw || sn) && hw >= 0) ? 1 : 0;
        e_way  = (rw || e_hit != 0) ? sel : 0;
        e_ev   = (rw && hw < 0 && m_mesi[idx][sel] != 0) ? 1 : 0;
        e_vtag = e_ev != 0 ? m_tag[idx][sel] : 0;
        e_vd   = (e_ev != 0 && m_mesi[idx][sel] == 3) ? 1 : 0;
        e_mcur = m_mesi[idx][sel];
        e_mhit = hw >= 0 ? 1 : 0;
        acc_cyc  = a;
        resp_cyc = a + lat;
        busy_lo  = a + 1;
        busy_hi  = a + lat;
        coh_lo   = coh ? a + 2 : 1;
        coh_hi   = coh ? a + 2 + stall : 0;
        c_old = c_new;
        if (rw) begin
            if (hw >= 0) c_new[0] = sat(c_new[0]);
            else         c_new[1] = sat(c_new[1]);
            if (e_ev != 0) c_new[2] = sat(c_new[2]);
            m_tag[idx][sel]  = tag;
            m_mesi[idx][sel] = nxt;
            touch(idx, sel);
        end else if (sn && hw >= 0) begin
            m_mesi[idx][sel] = nxt;
        end else if (op == 4) begin
            model_reset();
        end
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_idx   = IDX_W'(idx);
        req_tag   = TAG_W'(tag);
        @(negedge clk);
        req_valid      = 1'b0;
        req_op         = 3'($urandom);
        req_idx        = IDX_W'($urandom);
        req_tag        = TAG_W'($urandom);
        mesi_rsp_valid = 1'($urandom_range(0, 1));
        mesi_next      = 2'($urandom);
        if (coh)
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                mesi_rsp_valid = s == stall;
                mesi_next      = s == stall ? 2'(nxt) : 2'($urandom);
            end
        while (cyc <= a + lat) begin
            @(negedge clk);
            mesi_rsp_valid = 1'($urandom_range(0, 1));
            mesi_next      = 2'($urandom);
        end
    endtask

    initial begin
        int a, r, op, hc, mc;
        model_reset();
        c_new = '{0, 0, 0};
        c_old = '{0, 0, 0};
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("reset_ready", req_ready, 1);
        chk("reset_counts", hit_count + miss_count + evict_count, 0);
        @(negedge clk);

        txn(0, 3, 'h0AB, 0, 2);
        chk("miss1_hit", lr_hit, 0);
        chk("miss1_way", lr_way, 7);
        chk("miss1_evict", lr_ev, 0);
        chk("miss1_latency", lr_lat, 3);
        chk("miss1_miss_count", miss_count, 1);
        txn(0, 3, 'h0AB, 0, 2);
        chk("hit_mesi_cur", lr_mcur, 2);
        chk("hit_mesi_hit", lr_mhit, 1);
        chk("hit_resp_hit", lr_hit, 1);
        chk("hit_way", lr_way, 7);
        chk("hit_count_lit", hit_count, 1);
        txn(0, 3, 'h0AC, 0, 1);
        chk("lru_next_victim", lr_way, 6);

        for (int i = 0; i < 8; i++) txn(1, 5, 'h100 + i, 0, 3);
        txn(0, 5, 'h200, 0, 2);
        chk("evict_flag", lr_ev, 1);
        chk("evict_dirty", lr_vd, 1);
        chk("evict_tag", lr_vtag, 'h100);
        chk("evict_way", lr_way, 7);
        chk("evict_count_lit", evict_count, 1);
        txn(3, 5, 'h103, 0, 0);
        chk("snoop_inv_hit", lr_hit, 1);
        chk("snoop_inv_way", lr_way, 4);
        txn(0, 5, 'h300, 0, 2);
        chk("inv_pref_way", lr_way, 4);
        chk("inv_pref_evict", lr_ev, 0);
        txn(0, 5, 'h301, 0, 2);
        chk("post_snoop_victim_way", lr_way, 6);
        chk("post_snoop_victim_tag", lr_vtag, 'h101);
        txn(2, 5, 'h999, 0, 1);
        chk("snoop_miss_latency", lr_lat, 2);
        chk("snoop_miss_hit", lr_hit, 0);
        txn(0, 3, 'h0AB, 5, 2);
        chk("backpressure_latency", lr_lat, 8);
        chk("backpressure_mesi_cur", lr_mcur, 2);
        txn(6, 3, 'h0AB, 0, 0);
        chk("noop_latency", lr_lat, 2);
        chk("noop_hit", lr_hit, 0);

        // In-flight READ dropped by reset while waiting in COHERE.
        a = cyc;
        c_old = c_new;
        acc_cyc = a; resp_cyc = a + 1000; busy_lo = a + 1; busy_hi = a + 1000;
        coh_lo = a + 2; coh_hi = a + 1000; e_mcur = 0; e_mhit = 0;
        req_valid = 1'b1; req_op = 3'd0; req_idx = 4'd9; req_tag = 12'h055;
        @(negedge clk);
        req_valid = 1'b0;
        mesi_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        resp_cyc = -1; busy_lo = 1; busy_hi = 0; coh_lo = 1; coh_hi = 0;
        c_new = '{0, 0, 0};
        c_old = '{0, 0, 0};
        model_reset();
        #1;
        chk("async_rst_ready", req_ready, 1);
        chk("async_rst_mesi_req", mesi_req_valid, 0);
        chk("async_rst_resp_valid", resp_valid, 0);
        chk("async_rst_miss_count", miss_count, 0);
        chk("async_rst_hit_count", hit_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(0, 2, 'h011, 0, 2);
        txn(0, 2, 'h011, 1, 3);
        txn(1, 7, 'h022, 0, 3);
        hc = int'(hit_count);
        mc = int'(miss_count);
        txn(4, 0, 0, 0, 0);
        chk("clear_latency", lr_lat, SETS + 1);
        chk("clear_keeps_hits", hit_count, hc);
        chk("clear_keeps_misses", miss_count, mc);
        for (int s = 0; s < SETS; s++) begin
            txn(0, s, 'h7FF, 0, 1);
            chk("cleared_set_way", lr_way, WAYS - 1);
            chk("cleared_set_evict", lr_ev, 0);
        end

        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 99);
            op = r < 35 ? 0 : r < 60 ? 1 : r < 72 ? 2 : r < 84 ? 3 :
                 r < 90 ? $urandom_range(5, 7) : r < 93 ? 4 : 0;
            txn(op, $urandom_range(0, 3), $urandom_range(0, 11),
                $urandom_range(0, 9) == 0 ? $urandom_range(4, 7) : $urandom_range(0, 2),
                (op == 3 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3));
        end
        repeat (3) @(negedge clk);
        finish_up();
    end
endmodule

// File: doc/cache_way_engine.md
# cache_way_engine

Parametrised, sequential set-associative tag/MESI/LRU engine; one instance per cache (I-cache: WAYS=4, D-cache: WAYS=8).
- Owns tag, MESI and LRU-age arrays for all sets.
- Accepts one trace request at a time through a valid/ready handshake, detects hits, selects the victim (oldest invalid way first, else oldest way) and obtains the next MESI state from the coherence FSM.
- Commits exactly one array/LRU update per request.
- Sits between the trace-driven top level and the MESI FSM, and keeps hit/miss/eviction statistics.

## Interface
- WAYS, 8, associativity (power of 2, 2..16)
- SETS, 16, number of sets (power of 2)
- TAG_W, 12, tag width
- IDX_W, $clog2(SETS), set index width
- WAY_W, $clog2(WAYS), way index / LRU age width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  engine idle, request accepted when req_valid && req_ready
- req_op  in  3  0 READ, 1 WRITE, 2 SNOOP_RD, 3 SNOOP_INV, 4 CLEAR (others treated as no-op, resp_valid only)
- req_idx  in  IDX_W  set index
- req_tag  in  TAG_W  tag
- mesi_req_valid  out  1  coherence query pending
- mesi_cur  out  2  current MESI of selected way (I=0, S=1, E=2, M=3)
- mesi_hit  out  1  selected way is a hit
- mesi_rsp_valid  in  1  FSM answer valid
- mesi_next  in  2  next MESI for selected way
- resp_valid  out  1  one-cycle completion pulse
- resp_hit / resp_way  out  1 / WAY_W  hit flag, selected way
- resp_evict / resp_victim_dirty  out  1 / 1  valid line replaced / it was M
- resp_victim_tag  out  TAG_W  tag of replaced line
- hit_count, miss_count, evict_count  out  32 each  saturating statistics

## Operation
- Reset state: all MESI=I, tags 0, age of way w = w; counters 0; FSM in IDLE; every output 0 except req_ready=1.
- Hit: tag match with MESI≠I. At most one hit way (invariant).
- Victim, on READ/WRITE miss: the invalid way with the highest age; if there are none, the way with the highest age.
- States: IDLE → LOOKUP → COHERE → UPDATE → IDLE.
  - LOOKUP registers the set and computes hit and selected way.
  - COHERE holds mesi_req_valid/mesi_cur/mesi_hit stable until mesi_rsp_valid.
  - UPDATE writes the arrays and pulses resp_valid.
- SNOOP_RD/SNOOP_INV:
  - Miss: LOOKUP → UPDATE directly, resp_hit=0, no array change.
  - Hit: passes through COHERE and writes mesi_next only. Tag and LRU are untouched.
- READ/WRITE:
  - Selected way gets tag=req_tag and MESI=mesi_next.
  - LRU: every way with age < selected way's old age increments; selected way's age becomes 0. Ages remain a permutation of 0..WAYS-1.
  - A hit on an age-0 way changes no ages.
- Eviction: a READ/WRITE miss whose victim MESI≠I sets resp_evict=1, resp_victim_tag=old tag and resp_victim_dirty=(old MESI==M).
- Counters count READ/WRITE only: hit_count on a hit, miss_count on a miss, evict_count when resp_evict=1. Each saturates at 32'hFFFF_FFFF.
- CLEAR:
  - IDLE → CLEAR walks sets 0..SETS-1, one per cycle, restoring the reset contents.
  - Then UPDATE pulses resp_valid.
  - Counters are not cleared.
- resp_* fields are valid only while resp_valid=1 and are 0 otherwise.

## Timing
- Cycle 0: accept. Cycle 1: LOOKUP. Cycle 2: COHERE with mesi_req_valid=1.
- FSM answer in the same cycle: UPDATE at cycle 3 (resp_valid=1, arrays written at end of cycle 3); req_ready=1 at cycle 4.
- Snoop-miss latency is 2 cycles (resp_valid at cycle 2).
- CLEAR: resp_valid at cycle SETS+1.
- Each cycle mesi_rsp_valid stays low adds one cycle; mesi_rsp_valid is ignored outside COHERE.
- req_ready=1 only in IDLE; no request is queued.
- A request to the same set immediately after UPDATE sees the updated contents.
- rst_n low at any time:
  - Outputs and state return to reset values immediately (asynchronously).
  - The in-flight request is dropped, with no resp_valid and no counter change.

## Test plan
- **Post-reset READ miss:** reset, then READ idx 3 tag 0x0AB with FSM answering E in cycle 2 → resp_valid at cycle 3, resp_hit=0, resp_way=7, resp_evict=0, miss_count=1; ages of set 3: way7=0, way w=w+1 for w<7.
- **READ hit:** repeat the READ → mesi_cur=E, mesi_hit=1, resp_hit=1, resp_way=7, hit_count=1, ages unchanged.
- **Dirty eviction:** WRITE tags 0x100..0x107 to set 5 (FSM answers M), then READ tag 0x200 → resp_evict=1, resp_victim_dirty=1, resp_victim_tag=0x100, evict_count=1.
- **Invalid way preferred:** SNOOP_INV hit on tag 0x103 (FSM answers I), then READ miss tag 0x300 → resp_way = way holding 0x103, resp_evict=0, ages of other ways unchanged by the snoop.
- **FSM backpressure:** hold mesi_rsp_valid low 5 cycles → mesi_req_valid/mesi_cur stable and req_ready=0 throughout; resp_valid at cycle 8.
- **Reset and CLEAR:** assert rst_n low during COHERE → all outputs reset within the same cycle, no resp_valid. Then CLEAR with SETS=16 → resp_valid at cycle 17, every set back to the reset pattern, counters preserved.
